// File: rtl/cube_bbox_tracker.sv
// Per-frame first-hit / bounding-box / hit-count tracker fed by the cube-start detector.
// Optional squareness qualification is enabled with CUBE_BBOX_SQUARE_CHECK_EN.
module cube_bbox_tracker #(
  parameter int COORD_W    = 11,
  parameter int CNT_W      = 20,
  parameter int MIN_PIXELS = 64
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iFVAL,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  input  logic               iCubeDetected,
  output logic [COORD_W-1:0] oStartX,
  output logic [COORD_W-1:0] oStartY,
  output logic [COORD_W-1:0] oMinX,
  output logic [COORD_W-1:0] oMaxX,
  output logic [COORD_W-1:0] oMinY,
  output logic [COORD_W-1:0] oMaxY,
  output logic [CNT_W-1:0]   oPixelCount,
  output logic               oBoxValid,
  output logic               oFrameDone
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    SCAN  = 2'd2
  } state_e;

  localparam int unsigned MIN_EFF = (MIN_PIXELS < 1) ? 32'd1 : 32'(MIN_PIXELS);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  start_x_q, start_x_d, start_y_q, start_y_d;
  logic [COORD_W-1:0]  min_x_q, min_x_d, max_x_q, max_x_d;
  logic [COORD_W-1:0]  min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                first_seen_q, first_seen_d;

  logic [COORD_W-1:0]  out_sx_q, out_sx_d, out_sy_q, out_sy_d;
  logic [COORD_W-1:0]  out_mnx_q, out_mnx_d, out_mxx_q, out_mxx_d;
  logic [COORD_W-1:0]  out_mny_q, out_mny_d, out_mxy_q, out_mxy_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_done_q, out_done_d;

  logic                hit_s;
  logic                count_ok_s;
  logic                qualify_s;

`ifdef CUBE_BBOX_SQUARE_CHECK_EN
  // Box is "roughly square" when |W-H| <= max(W,H)/4, computed one bit wider than coordinates.
  function automatic logic square_ok(input logic [COORD_W-1:0] mnx, input logic [COORD_W-1:0] mxx,
                                     input logic [COORD_W-1:0] mny, input logic [COORD_W-1:0] mxy);
    logic [COORD_W:0] w, h, diff, big;
    w = {1'b0, mxx} - {1'b0, mnx} + {{COORD_W{1'b0}}, 1'b1};
    h = {1'b0, mxy} - {1'b0, mny} + {{COORD_W{1'b0}}, 1'b1};
    if (w > h) begin
      diff = w - h;
      big  = w;
    end else begin
      diff = h - w;
      big  = h;
    end
    return (diff <= (big >> 2));
  endfunction
`endif

  assign hit_s      = iFVAL & iDVAL & iCubeDetected;
  assign count_ok_s = (64'(count_q) >= 64'(MIN_EFF));

`ifdef CUBE_BBOX_SQUARE_CHECK_EN
  assign qualify_s = count_ok_s & square_ok(min_x_q, max_x_q, min_y_q, max_y_q);
`else
  assign qualify_s = count_ok_s;
`endif

  // Next-state, accumulation and publish logic.
  always_comb begin
    state_d      = state_q;
    start_x_d    = start_x_q;
    start_y_d    = start_y_q;
    min_x_d      = min_x_q;
    max_x_d      = max_x_q;
    min_y_d      = min_y_q;
    max_y_d      = max_y_q;
    count_d      = count_q;
    first_seen_d = first_seen_q;
    out_sx_d     = out_sx_q;
    out_sy_d     = out_sy_q;
    out_mnx_d    = out_mnx_q;
    out_mxx_d    = out_mxx_q;
    out_mny_d    = out_mny_q;
    out_mxy_d    = out_mxy_q;
    out_cnt_d    = out_cnt_q;
    out_valid_d  = out_valid_q;
    out_done_d   = 1'b0;

    case (state_q)
      SYNC: begin
        if (!iFVAL) begin
          state_d = ARMED;
        end else begin
          state_d = SYNC;
        end
      end

      ARMED: begin
        if (iFVAL) begin
          state_d = SCAN;
          // The frame's first cycle may itself carry a hit, so seed from it directly.
          if (hit_s) begin
            start_x_d    = iX_Cont;
            start_y_d    = iY_Cont;
            min_x_d      = iX_Cont;
            max_x_d      = iX_Cont;
            min_y_d      = iY_Cont;
            max_y_d      = iY_Cont;
            count_d      = {{(CNT_W-1){1'b0}}, 1'b1};
            first_seen_d = 1'b1;
          end else begin
            start_x_d    = {COORD_W{1'b0}};
            start_y_d    = {COORD_W{1'b0}};
            min_x_d      = {COORD_W{1'b1}};
            max_x_d      = {COORD_W{1'b0}};
            min_y_d      = {COORD_W{1'b1}};
            max_y_d      = {COORD_W{1'b0}};
            count_d      = {CNT_W{1'b0}};
            first_seen_d = 1'b0;
          end
        end else begin
          state_d = ARMED;
        end
      end

      SCAN: begin
        if (!iFVAL) begin
          state_d    = ARMED;
          out_done_d = 1'b1;
          out_cnt_d  = count_q;
          if (qualify_s) begin
            out_sx_d    = start_x_q;
            out_sy_d    = start_y_q;
            out_mnx_d   = min_x_q;
            out_mxx_d   = max_x_q;
            out_mny_d   = min_y_q;
            out_mxy_d   = max_y_q;
            out_valid_d = 1'b1;
          end else begin
            out_sx_d    = {COORD_W{1'b0}};
            out_sy_d    = {COORD_W{1'b0}};
            out_mnx_d   = {COORD_W{1'b0}};
            out_mxx_d   = {COORD_W{1'b0}};
            out_mny_d   = {COORD_W{1'b0}};
            out_mxy_d   = {COORD_W{1'b0}};
            out_valid_d = 1'b0;
          end
        end else if (hit_s) begin
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            count_d = count_q;
          end
          if (iX_Cont < min_x_q) begin
            min_x_d = iX_Cont;
          end else begin
            min_x_d = min_x_q;
          end
          if (iX_Cont > max_x_q) begin
            max_x_d = iX_Cont;
          end else begin
            max_x_d = max_x_q;
          end
          if (iY_Cont < min_y_q) begin
            min_y_d = iY_Cont;
          end else begin
            min_y_d = min_y_q;
          end
          if (iY_Cont > max_y_q) begin
            max_y_d = iY_Cont;
          end else begin
            max_y_d = max_y_q;
          end
          if (!first_seen_q) begin
            start_x_d    = iX_Cont;
            start_y_d    = iY_Cont;
            first_seen_d = 1'b1;
          end else begin
            first_seen_d = first_seen_q;
          end
        end else begin
          state_d = SCAN;
        end
      end

      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // State, working accumulators and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= SYNC;
      start_x_q    <= {COORD_W{1'b0}};
      start_y_q    <= {COORD_W{1'b0}};
      min_x_q      <= {COORD_W{1'b1}};
      max_x_q      <= {COORD_W{1'b0}};
      min_y_q      <= {COORD_W{1'b1}};
      max_y_q      <= {COORD_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      first_seen_q <= 1'b0;
      out_sx_q     <= {COORD_W{1'b0}};
      out_sy_q     <= {COORD_W{1'b0}};
      out_mnx_q    <= {COORD_W{1'b0}};
      out_mxx_q    <= {COORD_W{1'b0}};
      out_mny_q    <= {COORD_W{1'b0}};
      out_mxy_q    <= {COORD_W{1'b0}};
      out_cnt_q    <= {CNT_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_x_q    <= start_x_d;
      start_y_q    <= start_y_d;
      min_x_q      <= min_x_d;
      max_x_q      <= max_x_d;
      min_y_q      <= min_y_d;
      max_y_q      <= max_y_d;
      count_q      <= count_d;
      first_seen_q <= first_seen_d;
      out_sx_q     <= out_sx_d;
      out_sy_q     <= out_sy_d;
      out_mnx_q    <= out_mnx_d;
      out_mxx_q    <= out_mxx_d;
      out_mny_q    <= out_mny_d;
      out_mxy_q    <= out_mxy_d;
      out_cnt_q    <= out_cnt_d;
      out_valid_q  <= out_valid_d;
      out_done_q   <= out_done_d;
    end
  end

  assign oStartX     = out_sx_q;
  assign oStartY     = out_sy_q;
  assign oMinX       = out_mnx_q;
  assign oMaxX       = out_mxx_q;
  assign oMinY       = out_mny_q;
  assign oMaxY       = out_mxy_q;
  assign oPixelCount = out_cnt_q;
  assign oBoxValid   = out_valid_q;
  assign oFrameDone  = out_done_q;

endmodule

// File: tb/tb_cube_bbox_tracker.sv
// Scoreboard bench for cube_bbox_tracker: main instance with default parameters and a
// CNT_W=4 / MIN_PIXELS=0 instance for saturation; expectations follow CUBE_BBOX_SQUARE_CHECK_EN.
module tb_cube_bbox_tracker;

  logic        clk_s = 1'b0;
  logic        rst_n_s;
  logic        fval_s, fval2_s, dval_s, det_s;
  logic [10:0] x_s, y_s;

  logic [10:0] sx1, sy1, mnx1, mxx1, mny1, mxy1;
  logic [19:0] cnt1;
  logic        valid1, done1;
  logic [10:0] sx2, sy2, mnx2, mxx2, mny2, mxy2;
  logic [3:0]  cnt2;
  logic        valid2, done2;

  typedef struct {
    logic [10:0] sx, sy, mnx, mxx, mny, mxy;
    logic [31:0] cnt;
    logic        v;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  logic tgt2 = 1'b0;

`ifdef CUBE_BBOX_SQUARE_CHECK_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  cube_bbox_tracker dut1 (
    .iCLK(clk_s), .iRST_N(rst_n_s), .iFVAL(fval_s), .iDVAL(dval_s),
    .iX_Cont(x_s), .iY_Cont(y_s), .iCubeDetected(det_s),
    .oStartX(sx1), .oStartY(sy1), .oMinX(mnx1), .oMaxX(mxx1), .oMinY(mny1), .oMaxY(mxy1),
    .oPixelCount(cnt1), .oBoxValid(valid1), .oFrameDone(done1)
  );

  cube_bbox_tracker #(.COORD_W(11), .CNT_W(4), .MIN_PIXELS(0)) dut2 (
    .iCLK(clk_s), .iRST_N(rst_n_s), .iFVAL(fval2_s), .iDVAL(dval_s),
    .iX_Cont(x_s), .iY_Cont(y_s), .iCubeDetected(det_s),
    .oStartX(sx2), .oStartY(sy2), .oMinX(mnx2), .oMaxX(mxx2), .oMinY(mny2), .oMaxY(mxy2),
    .oPixelCount(cnt2), .oBoxValid(valid2), .oFrameDone(done2)
  );

  always #5 clk_s = ~clk_s;

  always @(posedge clk_s) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive one cycle of pixel inputs to the selected instance, then advance to posedge+1.
  task automatic step(input logic f, input logic d, input logic h,
                      input logic [10:0] x, input logic [10:0] y);
    if (tgt2) begin
      fval2_s = f;
      fval_s  = 1'b0;
    end else begin
      fval_s  = f;
      fval2_s = 1'b0;
    end
    dval_s = d;
    det_s  = h;
    x_s    = x;
    y_s    = y;
    @(posedge clk_s);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
  endtask

  // Frame body: a lead cycle without a hit, then a w x h hit block with distractor cycles per row.
  task automatic block(input int x0, input int w, input int y0, input int h);
    step(1'b1, 1'b1, 1'b0, 11'd1000, 11'd1000);
    for (int yy = y0; yy < y0 + h; yy++) begin
      for (int xx = x0; xx < x0 + w; xx++) step(1'b1, 1'b1, 1'b1, 11'(xx), 11'(yy));
      step(1'b1, 1'b0, 1'b1, 11'd2000, 11'd2000);
      step(1'b1, 1'b1, 1'b0, 11'd2001, 11'd2001);
    end
  endtask

  task automatic expect_pub(input bit which, input bit v, input int cnt,
                            input int sx, input int sy, input int mnx,
                            input int mxx, input int mny, input int mxy);
    exp_t e;
    e.cnt = 32'(cnt);
    e.v   = v;
    e.cyc = cyc + 1;
    e.sx  = v ? 11'(sx)  : 11'd0;
    e.sy  = v ? 11'(sy)  : 11'd0;
    e.mnx = v ? 11'(mnx) : 11'd0;
    e.mxx = v ? 11'(mxx) : 11'd0;
    e.mny = v ? 11'(mny) : 11'd0;
    e.mxy = v ? 11'(mxy) : 11'd0;
    if (which) q2.push_back(e);
    else q1.push_back(e);
  endtask

  // Last iFVAL-low cycle of a frame carries a hit at (700,500) that must be ignored.
  task automatic end_frame();
    step(1'b0, 1'b1, 1'b1, 11'd700, 11'd500);
  endtask

  // Main instance monitor.
  always @(negedge clk_s) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL dut1_unexpected_done: got pulse at cycle %0d expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_latency", 32'(cyc), 32'(e1.cyc));
        chk("dut1_count", 32'(cnt1), e1.cnt);
        chk("dut1_valid", 32'(valid1), 32'(e1.v));
        chk("dut1_startx", 32'(sx1), 32'(e1.sx));
        chk("dut1_starty", 32'(sy1), 32'(e1.sy));
        chk("dut1_minx", 32'(mnx1), 32'(e1.mnx));
        chk("dut1_maxx", 32'(mxx1), 32'(e1.mxx));
        chk("dut1_miny", 32'(mny1), 32'(e1.mny));
        chk("dut1_maxy", 32'(mxy1), 32'(e1.mxy));
      end
    end
  end

  // Saturation instance monitor.
  always @(negedge clk_s) begin
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        total++;
        $display("FAIL dut2_unexpected_done: got pulse at cycle %0d expected none", cyc);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_latency", 32'(cyc), 32'(e2.cyc));
        chk("dut2_count", 32'(cnt2), e2.cnt);
        chk("dut2_valid", 32'(valid2), 32'(e2.v));
        chk("dut2_startx", 32'(sx2), 32'(e2.sx));
        chk("dut2_starty", 32'(sy2), 32'(e2.sy));
        chk("dut2_minx", 32'(mnx2), 32'(e2.mnx));
        chk("dut2_maxx", 32'(mxx2), 32'(e2.mxx));
        chk("dut2_miny", 32'(mny2), 32'(e2.mny));
        chk("dut2_maxy", 32'(mxy2), 32'(e2.mxy));
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_startx"}, 32'(sx1), 32'd0);
    chk({tag, "_starty"}, 32'(sy1), 32'd0);
    chk({tag, "_minx"}, 32'(mnx1), 32'd0);
    chk({tag, "_maxx"}, 32'(mxx1), 32'd0);
    chk({tag, "_miny"}, 32'(mny1), 32'd0);
    chk({tag, "_maxy"}, 32'(mxy1), 32'd0);
    chk({tag, "_count"}, 32'(cnt1), 32'd0);
    chk({tag, "_valid"}, 32'(valid1), 32'd0);
    chk({tag, "_done"}, 32'(done1), 32'd0);
  endtask

  initial begin
    rst_n_s = 1'b0;
    fval_s = 1'b0; fval2_s = 1'b0; dval_s = 1'b0; det_s = 1'b0;
    x_s = 11'd0; y_s = 11'd0;
    repeat (3) @(posedge clk_s);
    #1;
    chk_zero_outputs("reset");
    chk("reset_dut2_count", 32'(cnt2), 32'd0);
    rst_n_s = 1'b1;
    idle(3);

    // 20x20 hit block, 400 hits.
    block(100, 20, 50, 20);
    expect_pub(1'b0, 1'b1, 400, 100, 50, 100, 119, 50, 69);
    end_frame();
    idle(3);

    // Ten hits: below threshold.
    block(5, 10, 3, 1);
    expect_pub(1'b0, 1'b0, 10, 0, 0, 0, 0, 0, 0);
    end_frame();
    idle(3);

    // Hit at (0,0) on the iFVAL-rising cycle, then an 8x8 grid at 1..8.
    step(1'b1, 1'b1, 1'b1, 11'd0, 11'd0);
    for (int yy = 1; yy <= 8; yy++)
      for (int xx = 1; xx <= 8; xx++) step(1'b1, 1'b1, 1'b1, 11'(xx), 11'(yy));
    expect_pub(1'b0, 1'b1, 65, 0, 0, 0, 8, 0, 8);
    end_frame();
    idle(3);

    // iFVAL glitch: two back-to-back frames separated by one low cycle.
    block(200, 8, 300, 9);
    expect_pub(1'b0, 1'b1, 72, 200, 300, 200, 207, 300, 308);
    end_frame();
    block(400, 8, 100, 8);
    expect_pub(1'b0, 1'b1, 64, 400, 100, 400, 407, 100, 107);
    end_frame();
    idle(3);

    // Reset mid-frame, then released while iFVAL is still high.
    block(10, 5, 10, 5);
    rst_n_s = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    step(1'b1, 1'b1, 1'b1, 11'd30, 11'd30);
    step(1'b1, 1'b1, 1'b1, 11'd31, 11'd30);
    rst_n_s = 1'b1;
    for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 1'b1, 11'(40 + i), 11'd40);
    end_frame();
    idle(3);
    block(20, 100, 30, 90);
    expect_pub(1'b0, 1'b1, 9000, 20, 30, 20, 119, 30, 119);
    end_frame();
    idle(3);

    // 100x20 block: fails squareness only when the check is built in.
    block(300, 100, 200, 20);
    expect_pub(1'b0, !SQ, 2000, 300, 200, 300, 399, 200, 219);
    end_frame();
    idle(3);

    // Saturating counter on the CNT_W=4 instance, 20 hits.
    tgt2 = 1'b1;
    block(0, 20, 7, 1);
    expect_pub(1'b1, !SQ, 15, 0, 7, 0, 19, 7, 7);
    end_frame();
    tgt2 = 1'b0;
    idle(10);

    chk("dut1_queue_empty", 32'(q1.size()), 32'd0);
    chk("dut2_queue_empty", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cube_bbox_tracker.md
Name: cube_bbox_tracker

Overview:
- Sits directly downstream of the per-pixel cube-start detector in the DE2 CCD capture path.
- Consumes the detector's per-pixel hit flag and raster coordinates, and accumulates per-frame statistics: first-hit coordinate, bounding box and hit count.
- At each frame end, publishes one registered, qualified result for the facelet-sampling stage.

Parameters:
- COORD_W, 11: width of X/Y coordinates.
- CNT_W, 20: width of the hit counter.
- MIN_PIXELS, 64: minimum hits for a valid box; values below 1 are treated as 1.

Ports:
- iCLK, input, 1: pixel clock.
- iRST_N, input, 1: asynchronous active-low reset.
- iFVAL, input, 1: frame valid from CCD capture.
- iDVAL, input, 1: pixel valid strobe.
- iX_Cont, input, COORD_W: current pixel X.
- iY_Cont, input, COORD_W: current pixel Y.
- iCubeDetected, input, 1: detector hit for the current pixel.
- oStartX, output, COORD_W: X of the first hit in raster order.
- oStartY, output, COORD_W: Y of the first hit in raster order.
- oMinX, output, COORD_W: bounding-box left edge.
- oMaxX, output, COORD_W: bounding-box right edge.
- oMinY, output, COORD_W: bounding-box top edge.
- oMaxY, output, COORD_W: bounding-box bottom edge.
- oPixelCount, output, CNT_W: saturating hit count for the last frame.
- oBoxValid, output, 1: last published result is qualified.
- oFrameDone, output, 1: one-cycle pulse when results update.

Behaviour:
- One clock domain, iCLK; reset is asynchronous and active-low on iRST_N.
- Reset state:
  - All outputs are 0 and the FSM is in SYNC.
  - Working registers: min regs all-ones, max regs 0, count 0, first_seen 0.
- A qualified hit is iFVAL & iDVAL & iCubeDetected, sampled at the rising edge of iCLK.
- FSM states:
  - SYNC: wait for iFVAL=0, then go to ARMED. This prevents counting a partial frame when reset releases mid-frame.
  - ARMED: on iFVAL=1, go to SCAN. On that same edge, initialise the working registers. If the current cycle is a qualified hit, the initialised registers already include it (count=1, start/min/max set to its coordinates).
  - SCAN, each qualified hit:
    - count increments, saturating at 2^CNT_W-1.
    - minX=min(minX,X), maxX=max(maxX,X), minY=min(minY,Y), maxY=max(maxY,Y), all unsigned compares.
    - If first_seen=0, latch start=(X,Y) and set first_seen=1.
  - SCAN, on the first edge that samples iFVAL=0:
    - Publish results and go to ARMED.
    - Any pixel in that cycle is ignored.
- Publish rule (outputs registered, all updated on the same edge):
  - oPixelCount = count; oFrameDone = 1 for exactly one cycle.
  - If count >= max(MIN_PIXELS,1) and the optional check passes: start/box outputs take the working values and oBoxValid=1.
  - Otherwise: start/box outputs are 0 and oBoxValid=0.
- Latency: results appear one cycle after the last iFVAL-high cycle.
- Outputs hold between publishes. oFrameDone is 0 except on publish cycles.
- An iFVAL glitch (1→0→1) produces two separate frames, each published.
- Asserting iRST_N low mid-SCAN discards the accumulation immediately. Outputs go to 0 asynchronously. No oFrameDone pulse is produced for the aborted frame.
- iDVAL=0 cycles never modify state.

Optional Feature:
- Macro: CUBE_BBOX_SQUARE_CHECK_EN.
- Defined:
  - Compute W=maxX-minX+1 and H=maxY-minY+1 at COORD_W+1 bits.
  - The box qualifies only if |W-H| <= (max(W,H)>>2), i.e. roughly square.
  - If it fails, the result is published with oBoxValid=0 and zeroed box/start outputs; oPixelCount is still reported.
  - The check adds no latency: the compare completes in the publish cycle, registered alongside the other outputs.
- Not defined: qualification uses the pixel count only.

Test Plan:
- Hit block, default params:
  - Stimulus: reset; one frame with hits over X 100..119, Y 50..69 (400 hits).
  - Response: oFrameDone pulses one cycle after iFVAL falls. Start=(100,50), min/max X=100/119, Y=50/69, oPixelCount=400, oBoxValid=1.
- Below threshold:
  - Stimulus: frame with 10 hits at X=5..14, Y=3.
  - Response: oPixelCount=10, oBoxValid=0, all box/start outputs 0.
- Reset released mid-frame:
  - Stimulus: release iRST_N while iFVAL=1, with hits present.
  - Response: no oFrameDone for that frame. The next full frame publishes correctly.
- Boundary pixels:
  - Stimulus: a hit in the same cycle iFVAL rises at (0,0), plus a hit in the cycle iFVAL is sampled low at (700,500).
  - Response: (0,0) is counted and start=(0,0). (700,500) is ignored, so maxX and maxY do not include it.
- Saturation:
  - Stimulus: CNT_W=4, frame with 20 hits.
  - Response: oPixelCount=15.
- Square check (CUBE_BBOX_SQUARE_CHECK_EN defined):
  - Stimulus: 100x20 hit block with MIN_PIXELS=64.
  - Response: oBoxValid=0, oPixelCount=2000. A 100x90 block gives oBoxValid=1.
